// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU, its issue stage and their benches.
package alu_pkg;

    // ALU command encoding
    localparam logic [1:0] CMD_AND = 2'b00;
    localparam logic [1:0] CMD_OR  = 2'b01;
    localparam logic [1:0] CMD_ADD = 2'b10;
    localparam logic [1:0] CMD_SUB = 2'b11;

    // Issue-stage FSM: waiting for work, ALU computing, result held for downstream
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_issue.sv
// Issue/writeback stage around the combinational ALU: registers operands on a
// request handshake, captures the ALU result one cycle later into the output
// register and accumulator, and holds it on a valid/ready result port.
module alu_issue
    import alu_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_cmd,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_use_acc,
    input  logic             clr_acc,
    output logic [1:0]       alu_cmd,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    input  logic [W-1:0]     alu_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_zero,
    output logic [W-1:0]     acc,
    output logic [CNT_W-1:0] op_cnt
);

    state_e             state_q, state_d;
    logic [1:0]         alu_cmd_q, alu_cmd_d;
    logic [W-1:0]       alu_a_q, alu_a_d;
    logic [W-1:0]       alu_b_q, alu_b_d;
    logic [W-1:0]       out_data_q, out_data_d;
    logic [W-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]   op_cnt_q, op_cnt_d;

    logic accept;
    logic out_hs;

    // Handshake decode; in_ready looks at out_ready so a result can retire and
    // a new request enter on the same edge.
    assign in_ready = (state_q == IDLE) || ((state_q == RESP) && out_ready);
    assign accept   = in_valid && in_ready;
    assign out_hs   = (state_q == RESP) && out_ready;

    // Next-state logic for the issue FSM
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (out_hs) state_d = accept ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: operand capture, result capture, accumulator, counter
    always_comb begin
        alu_cmd_d  = alu_cmd_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        out_data_d = out_data_q;
        acc_d      = acc_q;
        op_cnt_d   = op_cnt_q;

        // Operand A reads acc_q, the value before this edge, so a chained
        // request ignores a clear landing on the same edge.
        if (accept) begin
            alu_cmd_d = in_cmd;
            alu_a_d   = in_use_acc ? acc_q : in_a;
            alu_b_d   = in_b;
        end

        // Result capture takes priority over a simultaneous clear.
        if (state_q == EXEC) begin
            out_data_d = alu_out;
            acc_d      = alu_out;
        end else if (clr_acc) begin
            acc_d = '0;
        end

        if (out_hs) begin
            op_cnt_d = op_cnt_q + CNT_W'(1);
        end
    end

    // State and datapath registers; reset discards any in-flight request
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values computed above.
        if (!rst_n) begin
            state_q    <= IDLE;
            alu_cmd_q  <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            out_data_q <= '0;
            acc_q      <= '0;
            op_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            alu_cmd_q  <= alu_cmd_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            out_data_q <= out_data_d;
            acc_q      <= acc_d;
            op_cnt_q   <= op_cnt_d;
        end
    end

    assign alu_cmd   = alu_cmd_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign out_valid = (state_q == RESP);
    assign out_data  = out_data_q;
    assign out_zero  = (out_data_q == '0);
    assign acc       = acc_q;
    assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue with a behavioural ALU beside it.
module tb_alu_issue;
    import alu_pkg::*;

    logic       clk, rst_n;
    logic       in_valid, in_ready;
    logic [1:0] in_cmd;
    logic [3:0] in_a, in_b;
    logic       in_use_acc, clr_acc;
    logic [1:0] alu_cmd;
    logic [3:0] alu_a, alu_b, alu_out;
    logic       out_valid, out_ready, out_zero;
    logic [3:0] out_data, acc;
    logic [7:0] op_cnt;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] cnt_exp = 0;

    alu_issue #(.W(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
        .in_a(in_a), .in_b(in_b), .in_use_acc(in_use_acc), .clr_acc(clr_acc),
        .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .acc(acc), .op_cnt(op_cnt)
    );

    // Reference ALU: plain modulo-16 arithmetic
    function automatic logic [3:0] alu_f(input logic [1:0] c, input logic [3:0] a, input logic [3:0] b);
        int r;
        case (c)
            CMD_AND: r = int'(a & b);
            CMD_OR:  r = int'(a | b);
            CMD_ADD: r = int'(a) + int'(b);
            default: r = int'(a) - int'(b) + 16;
        endcase
        return 4'(r % 16);
    endfunction

    assign alu_out = alu_f(alu_cmd, alu_a, alu_b);

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait (bounded) for in_ready, complete the accept edge.
    task automatic issue(input logic [1:0] c, input logic [3:0] a, input logic [3:0] b, input logic ua);
        in_valid = 1; in_cmd = c; in_a = a; in_b = b; in_use_acc = ua;
        #1;
        for (int i = 0; i < 50 && !in_ready; i++) tick();
        check("issue_ready", int'(in_ready), 1);
        tick();
        in_valid = 0; in_use_acc = 0;
    endtask

    // Retire a result with out_ready high and confirm the counter advanced.
    task automatic finish_op();
        out_ready = 1;
        tick();
        cnt_exp++;
        check("op_cnt", int'(op_cnt), int'(cnt_exp));
        check("valid_drop", int'(out_valid), 0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        #12;
        @(negedge clk);
        rst_n = 1;
        cnt_exp = 0;
        tick();
    endtask

    typedef struct {
        logic [1:0] cmd;
        logic [3:0] a, b;
        logic       use_acc;
        logic [3:0] exp_a;
        logic [3:0] exp_res;
    } vec_t;

    vec_t vecs[8];

    // Cycle-level model state for the random phase
    int         m_busy;   // 0 free, 1 computing, 2 result waiting
    logic [3:0] m_acc, m_res, m_a, m_b, acc_before;
    logic [1:0] m_cmd;
    logic [7:0] m_cnt;
    logic       exp_ready, hs, take;

    initial begin
        rst_n = 0; in_valid = 0; in_cmd = 0; in_a = 0; in_b = 0;
        in_use_acc = 0; clr_acc = 0; out_ready = 1;

        vecs[0] = '{CMD_ADD, 4'h9, 4'h8, 1'b0, 4'h9, 4'h1};
        vecs[1] = '{CMD_ADD, 4'h3, 4'h4, 1'b0, 4'h3, 4'h7};
        vecs[2] = '{CMD_SUB, 4'hF, 4'h7, 1'b1, 4'h7, 4'h0};
        vecs[3] = '{CMD_SUB, 4'h2, 4'h5, 1'b0, 4'h2, 4'hD};
        vecs[4] = '{CMD_AND, 4'hC, 4'hA, 1'b0, 4'hC, 4'h8};
        vecs[5] = '{CMD_OR,  4'h0, 4'h3, 1'b1, 4'h8, 4'hB};
        vecs[6] = '{CMD_ADD, 4'hF, 4'hF, 1'b0, 4'hF, 4'hE};
        vecs[7] = '{CMD_SUB, 4'h0, 4'h1, 1'b1, 4'hE, 4'hD};

        // Reset values while held in reset
        #3;
        check("rst_alu_cmd", int'(alu_cmd), 0);
        check("rst_alu_a", int'(alu_a), 0);
        check("rst_alu_b", int'(alu_b), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_acc", int'(acc), 0);
        check("rst_op_cnt", int'(op_cnt), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_zero", int'(out_zero), 1);
        check("rst_in_ready", int'(in_ready), 1);
        do_reset();

        // Table: one op at a time with out_ready high
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].use_acc);
            check($sformatf("v%0d_alu_cmd", i), int'(alu_cmd), int'(vecs[i].cmd));
            check($sformatf("v%0d_alu_a", i), int'(alu_a), int'(vecs[i].exp_a));
            check($sformatf("v%0d_alu_b", i), int'(alu_b), int'(vecs[i].b));
            check($sformatf("v%0d_exec_valid", i), int'(out_valid), 0);
            tick();
            check($sformatf("v%0d_valid", i), int'(out_valid), 1);
            check($sformatf("v%0d_data", i), int'(out_data), int'(vecs[i].exp_res));
            check($sformatf("v%0d_zero", i), int'(out_zero), int'(vecs[i].exp_res == 0));
            check($sformatf("v%0d_acc", i), int'(acc), int'(vecs[i].exp_res));
            finish_op();
        end

        // Back-to-back chaining: accept on the RESP handshake sees fresh result
        issue(CMD_ADD, 4'h3, 4'h4, 1'b0);
        tick();
        check("chain_first", int'(out_data), 7);
        in_valid = 1; in_cmd = CMD_SUB; in_use_acc = 1; in_a = 4'h5; in_b = 4'h7;
        #1;
        check("chain_ready_resp", int'(in_ready), 1);
        tick();
        cnt_exp++;
        in_valid = 0; in_use_acc = 0;
        check("chain_exec", int'(out_valid), 0);
        check("chain_alu_a", int'(alu_a), 7);
        check("chain_op_cnt", int'(op_cnt), int'(cnt_exp));
        tick();
        check("chain_data", int'(out_data), 0);
        check("chain_zero", int'(out_zero), 1);
        finish_op();

        // Backpressure: result held, no second accept until release
        out_ready = 0;
        issue(CMD_AND, 4'hC, 4'hA, 1'b0);
        tick();
        in_valid = 1; in_cmd = CMD_ADD; in_a = 4'h5; in_b = 4'h4;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_valid", int'(out_valid), 1);
            check("bp_data", int'(out_data), 8);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_alu_a", int'(alu_a), 12);
            tick();
        end
        out_ready = 1;
        #1;
        check("bp_release_ready", int'(in_ready), 1);
        tick();
        cnt_exp++;
        in_valid = 0;
        check("bp_hs_cnt", int'(op_cnt), int'(cnt_exp));
        check("bp_second_alu_a", int'(alu_a), 5);
        tick();
        check("bp_second_data", int'(out_data), 9);
        finish_op();

        // Accumulator clear in IDLE, then chained OR
        issue(CMD_ADD, 4'h3, 4'h3, 1'b0);
        tick();
        finish_op();
        check("clr_acc_before", int'(acc), 6);
        clr_acc = 1;
        tick();
        clr_acc = 0;
        check("clr_acc_after", int'(acc), 0);
        issue(CMD_OR, 4'hF, 4'h3, 1'b1);
        tick();
        check("clr_or_data", int'(out_data), 3);
        finish_op();

        // Clear during EXEC loses to the capture
        issue(CMD_ADD, 4'h1, 4'h1, 1'b0);
        clr_acc = 1;
        tick();
        clr_acc = 0;
        check("clr_exec_acc", int'(acc), 2);
        finish_op();

        // Clear on the accept edge: operand uses the pre-clear value
        clr_acc = 1;
        issue(CMD_OR, 4'h0, 4'h0, 1'b1);
        clr_acc = 0;
        check("clr_accept_alu_a", int'(alu_a), 2);
        check("clr_accept_acc", int'(acc), 0);
        tick();
        check("clr_accept_data", int'(out_data), 2);
        finish_op();

        // Reset mid-operation while holding result 5
        out_ready = 0;
        issue(CMD_ADD, 4'h2, 4'h3, 1'b0);
        tick();
        check("rstmid_pre_data", int'(out_data), 5);
        #2;
        rst_n = 0;
        #1;
        check("rstmid_valid", int'(out_valid), 0);
        check("rstmid_acc", int'(acc), 0);
        check("rstmid_cnt", int'(op_cnt), 0);
        @(negedge clk);
        rst_n = 1;
        cnt_exp = 0;
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rstmid_no_valid", int'(out_valid), 0);
            check("rstmid_ready", int'(in_ready), 1);
        end

        // Counter wrap over 256 operations with random operands
        for (int k = 1; k <= 256; k++) begin
            logic [1:0] c;
            logic [3:0] a, b;
            c = 2'($urandom_range(0, 3));
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            issue(c, a, b, 1'b0);
            tick();
            check("wrap_data", int'(out_data), int'(alu_f(c, a, b)));
            out_ready = 1;
            tick();
            if (k == 255) check("wrap_cnt_255", int'(op_cnt), 255);
            if (k == 256) check("wrap_cnt_0", int'(op_cnt), 0);
        end

        // Random cycle-level phase against the model
        do_reset();
        m_busy = 0; m_acc = 0; m_res = 0; m_cnt = 0; m_a = 0; m_b = 0; m_cmd = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid   = 1'($urandom_range(0, 1));
            out_ready  = ($urandom_range(0, 3) != 0);
            clr_acc    = ($urandom_range(0, 4) == 0);
            in_use_acc = 1'($urandom_range(0, 1));
            in_cmd     = 2'($urandom_range(0, 3));
            in_a       = 4'($urandom_range(0, 15));
            in_b       = 4'($urandom_range(0, 15));
            #1;
            exp_ready = (m_busy == 0) || (m_busy == 2 && out_ready);
            check("rnd_in_ready", int'(in_ready), int'(exp_ready));
            check("rnd_out_valid", int'(out_valid), int'(m_busy == 2));
            if (m_busy == 2) begin
                check("rnd_out_data", int'(out_data), int'(m_res));
                check("rnd_out_zero", int'(out_zero), int'(m_res == 0));
            end
            check("rnd_acc", int'(acc), int'(m_acc));
            check("rnd_op_cnt", int'(op_cnt), int'(m_cnt));

            acc_before = m_acc;
            hs   = (m_busy == 2) && out_ready;
            take = in_valid && exp_ready;
            if (m_busy == 1) begin
                m_res  = alu_f(m_cmd, m_a, m_b);
                m_acc  = m_res;
                m_busy = 2;
            end else begin
                if (clr_acc) m_acc = 0;
                if (hs) begin
                    m_cnt++;
                    m_busy = 0;
                end
                if (take) m_busy = 1;
            end
            if (take) begin
                m_cmd = in_cmd;
                m_a   = in_use_acc ? acc_before : in_a;
                m_b   = in_b;
            end
            tick();
        end

        in_valid = 0; clr_acc = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
